miner_ctrl: RTL and testbench

Nonce-search controller that drives the `miner` double-SHA-256 core from the other end of its block/hashed/done interface. It holds a 76-byte header prefix loaded by word writes, and sweeps an inclusive nonce range. For each nonce it launches the miner, waits for `done`, and compares the byte-reversed digest against a 256-bit target. It stops on the first hit, on range exhaustion, or on a miner timeout, and reports the result to the host.

---
 rtl/miner_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_miner_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_ctrl.sv
// Nonce-search controller: sweeps an inclusive nonce range through an external double-SHA-256 miner and reports hit/exhaust/timeout.
// Latency: start -> LAUNCH next cycle; per nonce 3 cycles plus miner latency; result visible the cycle after miner_done.
// Backpressure: none; start and header writes are dropped while busy, miner_done is only honoured in WAIT.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   hdr_we/hdr_addr/hdr_wdata       header word writes (words 0..18), IDLE only
//   target, nonce_start, nonce_end  search parameters, latched on accepted start
//   start                           one-cycle search request
//   busy, found, exhausted, timeout status; flags held until next accepted start
//   result_nonce, result_hash       last completed attempt (hash in display byte order)
//   miner_block, miner_rst          drive to the miner core
//   miner_hashed, miner_done        digest and completion from the miner core
module miner_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hdr_we,
    input  logic [4:0]   hdr_addr,
    input  logic [31:0]  hdr_wdata,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         start,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout,
    output logic [31:0]  result_nonce,
    output logic [255:0] result_hash,
    output logic [639:0] miner_block,
    output logic         miner_rst,
    input  logic [255:0] miner_hashed,
    input  logic         miner_done
);

    localparam int HDR_WORDS = 19;
    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    nonce_end_q, nonce_end_d;
    logic [255:0]   target_q, target_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           found_q, found_d;
    logic           exhausted_q, exhausted_d;
    logic           timeout_q, timeout_d;
    logic [31:0]    res_nonce_q, res_nonce_d;
    logic [255:0]   res_hash_q, res_hash_d;
    logic [31:0]    hdr_q [HDR_WORDS];
    logic           hdr_wr;

    // The miner returns the digest in SHA byte order; the numeric/display
    // value used for the target compare is its byte reversal.
    function automatic logic [255:0] byte_rev(input logic [255:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[255-8*i -: 8];
        end
        return r;
    endfunction

    // Header writes are accepted in IDLE, including the cycle start is taken,
    // so that write is already visible in LAUNCH.
    assign hdr_wr = hdr_we && (state_q == S_IDLE) && (hdr_addr < 5'(HDR_WORDS));

    always_comb begin
        state_d     = state_q;
        nonce_d     = nonce_q;
        nonce_end_d = nonce_end_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        timeout_d   = timeout_q;
        res_nonce_d = res_nonce_q;
        res_hash_d  = res_hash_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    nonce_d     = nonce_start;
                    nonce_end_d = nonce_end;
                    target_d    = target;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (miner_done) begin
                    res_hash_d  = byte_rev(miner_hashed);
                    res_nonce_d = nonce_q;
                    state_d     = S_CHECK;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (res_hash_q <= target_q) begin
                    found_d = 1'b1;
                    state_d = S_IDLE;
                end else if (nonce_q == nonce_end_q) begin
                    exhausted_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    // Natural 32-bit wrap gives the 0xFFFFFFFF -> 0 sweep.
                    nonce_d = nonce_q + 32'd1;
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            nonce_q     <= '0;
            nonce_end_q <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            timeout_q   <= 1'b0;
            res_nonce_q <= '0;
            res_hash_q  <= '0;
            for (int i = 0; i < HDR_WORDS; i++) begin
                hdr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            nonce_end_q <= nonce_end_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
            timeout_q   <= timeout_d;
            res_nonce_q <= res_nonce_d;
            res_hash_q  <= res_hash_d;
            if (hdr_wr) begin
                hdr_q[hdr_addr] <= hdr_wdata;
            end
        end
    end

    always_comb begin
        miner_block = '0;
        for (int i = 0; i < HDR_WORDS; i++) begin
            miner_block[639-32*i -: 32] = hdr_q[i];
        end
        // Nonce goes into the block little-endian, as in the raw header.
        miner_block[31:0] = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
    end

    // Miner is held in reset everywhere except while a digest is pending or
    // being checked, so each LAUNCH gives exactly one reset pulse per nonce.
    assign miner_rst    = (state_q == S_IDLE) || (state_q == S_LAUNCH);
    assign busy         = (state_q != S_IDLE);
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign timeout      = timeout_q;
    assign result_nonce = res_nonce_q;
    assign result_hash  = res_hash_q;

endmodule

// File: tb/tb_miner_ctrl.sv
// Directed testbench for miner_ctrl with a behavioural stub miner.
// Stub returns a known digest for the genesis nonce and a large value for others.
// Stub can be set to never assert done to exercise the timeout path.
module tb_miner_ctrl;

    localparam int TO = 16;
    localparam logic [31:0]  GEN_NONCE = 32'h7C2BAC1D;
    localparam logic [255:0] GEN_DISP  = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_RAW   = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] GEN_TGT   = 256'h00000000FFFF0000000000000000000000000000000000000000000000000000;
    localparam logic [255:0] ONES      = {256{1'b1}};

    logic         clk;
    logic         rst;
    logic         hdr_we;
    logic [4:0]   hdr_addr;
    logic [31:0]  hdr_wdata;
    logic [255:0] target;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic         start;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         timeout;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic [639:0] miner_block;
    logic         miner_rst;
    logic [255:0] miner_hashed;
    logic         miner_done;

    miner_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .hdr_we       (hdr_we),
        .hdr_addr     (hdr_addr),
        .hdr_wdata    (hdr_wdata),
        .target       (target),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .start        (start),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .timeout      (timeout),
        .result_nonce (result_nonce),
        .result_hash  (result_hash),
        .miner_block  (miner_block),
        .miner_rst    (miner_rst),
        .miner_hashed (miner_hashed),
        .miner_done   (miner_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Genesis block header bytes 0..75 as big-endian 32-bit words.
    logic [31:0] gw [0:18] = '{
        32'h01000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3ba3edfd,
        32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132,
        32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d
    };

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] brev(input logic [255:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = v[255-8*i -: 8];
        return r;
    endfunction

    // Display-order digest the stub produces for nonce n.
    function automatic logic [255:0] disp_of(input logic [31:0] n);
        if (n == GEN_NONCE) return GEN_DISP;
        return {n ^ 32'hA5A5A5A5, 224'h0123456789abcdef0123456789abcdef0123456789abcdef01234567};
    endfunction

    function automatic logic [255:0] raw_of(input logic [31:0] n);
        if (n == GEN_NONCE) return GEN_RAW;
        return brev(disp_of(n));
    endfunction

    // Stub miner: done after 'lat' cycles out of reset unless 'hang'.
    logic        hang = 1'b0;
    int          lat  = 3;
    int          mcnt = 0;
    logic [31:0] att [$];

    always @(negedge clk) begin
        logic [31:0] n;
        n = {miner_block[7:0], miner_block[15:8], miner_block[23:16], miner_block[31:24]};
        if (miner_rst) begin
            mcnt = 0;
            miner_done = 1'b0;
            if (busy) att.push_back(n);
        end else begin
            mcnt++;
            if (!hang && mcnt >= lat) miner_done = 1'b1;
        end
        miner_hashed = raw_of(n);
    end

    // Issue a start and check the LAUNCH cycle that follows.
    task automatic run(input string tag, input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
        @(negedge clk);
        att.delete();
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_launch_busy"}, busy, 1);
        check_val({tag, "_launch_mrst"}, miner_rst, 1);
        check_val({tag, "_launch_nonce"}, miner_block[31:0], {ns[7:0], ns[15:8], ns[23:16], ns[31:24]});
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [639:0] exp_blk;
        int w;

        rst = 1'b1; hdr_we = 1'b0; hdr_addr = '0; hdr_wdata = '0;
        target = '0; nonce_start = '0; nonce_end = '0; start = 1'b0;
        miner_done = 1'b0; miner_hashed = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_val("rst_busy", busy, 0);
        check_val("rst_found", found, 0);
        check_val("rst_exh", exhausted, 0);
        check_val("rst_to", timeout, 0);
        check_val("rst_rnonce", result_nonce, 0);
        check_val("rst_rhash", result_hash, 0);
        check_val("rst_mrst", miner_rst, 1);
        check_val("rst_blk_hi", miner_block[639:320], 0);
        check_val("rst_blk_lo", miner_block[319:0], 0);

        // Load header, then a write to an unmapped word must change nothing.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            hdr_we = 1'b1; hdr_addr = 5'(i); hdr_wdata = gw[i];
        end
        @(negedge clk);
        hdr_addr = 5'd19; hdr_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        hdr_we = 1'b0;
        exp_blk = '0;
        for (int i = 0; i < 19; i++) exp_blk[639-32*i -: 32] = gw[i];
        check_val("hdr_blk_hi", miner_block[639:320], exp_blk[639:320]);
        check_val("hdr_blk_lo", miner_block[319:0], exp_blk[319:0]);

        // Genesis single attempt.
        run("gen", GEN_NONCE, GEN_NONCE, GEN_TGT);
        check_val("gen_blk_w0", miner_block[639:608], 32'h01000000);
        wait_idle("gen");
        check_val("gen_found", found, 1);
        check_val("gen_exh", exhausted, 0);
        check_val("gen_to", timeout, 0);
        check_val("gen_rnonce", result_nonce, GEN_NONCE);
        check_val("gen_rhash", result_hash, GEN_DISP);
        check_val("gen_att", att.size(), 1);

        // Three-nonce range ending at the genesis nonce.
        run("rng", 32'h7C2BAC1B, GEN_NONCE, GEN_TGT);
        wait_idle("rng");
        check_val("rng_found", found, 1);
        check_val("rng_rnonce", result_nonce, GEN_NONCE);
        check_val("rng_att", att.size(), 3);
        if (att.size() == 3) check_val("rng_att0", att[0], 32'h7C2BAC1B);

        // Miss range 0..2; start and header write during busy are ignored.
        run("exh", 32'd0, 32'd2, GEN_TGT);
        @(negedge clk);
        start = 1'b1; nonce_start = GEN_NONCE; nonce_end = GEN_NONCE;
        hdr_we = 1'b1; hdr_addr = 5'd0; hdr_wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; hdr_we = 1'b0;
        wait_idle("exh");
        check_val("exh_exh", exhausted, 1);
        check_val("exh_found", found, 0);
        check_val("exh_rnonce", result_nonce, 32'd2);
        check_val("exh_rhash", result_hash, disp_of(32'd2));
        check_val("exh_att", att.size(), 3);
        check_val("exh_hdr_kept", miner_block[639:608], 32'h01000000);

        // Wrap-around with impossible target.
        run("wrap0", 32'hFFFFFFFF, 32'h00000000, 256'd0);
        wait_idle("wrap0");
        check_val("wrap0_exh", exhausted, 1);
        check_val("wrap0_found", found, 0);
        check_val("wrap0_att", att.size(), 2);
        if (att.size() == 2) begin
            check_val("wrap0_att0", att[0], 32'hFFFFFFFF);
            check_val("wrap0_att1", att[1], 32'h00000000);
        end
        check_val("wrap0_rnonce", result_nonce, 32'h00000000);

        // Wrap-around with always-hit target.
        run("wrap1", 32'hFFFFFFFF, 32'h00000000, ONES);
        wait_idle("wrap1");
        check_val("wrap1_found", found, 1);
        check_val("wrap1_exh", exhausted, 0);
        check_val("wrap1_rnonce", result_nonce, 32'hFFFFFFFF);
        check_val("wrap1_att", att.size(), 1);

        // Timeout: miner never completes; count WAIT cycles.
        hang = 1'b1;
        run("to", 32'd5, 32'd9, ONES);
        w = 0;
        for (int k = 0; k < 200 && busy; k++) begin
            @(negedge clk);
            if (busy && !miner_rst) w++;
        end
        check_val("to_idle", busy, 0);
        check_val("to_flag", timeout, 1);
        check_val("to_found", found, 0);
        check_val("to_exh", exhausted, 0);
        check_val("to_waits", w, TO);

        // Reset asserted during WAIT.
        run("mrst", 32'd5, 32'd9, ONES);
        repeat (3) @(negedge clk);
        check_val("mrst_busy_pre", busy, 1);
        check_val("mrst_mrst_pre", miner_rst, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mrst_busy", busy, 0);
        check_val("mrst_found", found, 0);
        check_val("mrst_exh", exhausted, 0);
        check_val("mrst_to", timeout, 0);
        check_val("mrst_mrst", miner_rst, 1);
        check_val("mrst_rnonce", result_nonce, 0);
        check_val("mrst_blk_hi", miner_block[639:320], 0);
        hang = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
